fpro_bus_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one FPro bus between two masters (M0 = MCS bridge, M1 = DMA/aux).

---
 rtl/fpro_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fpro_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpro_bus_arbiter.sv
// fpro_bus_arbiter: round-robin arbiter that shares one FPro bus between two
// single-word masters (M0 = MCS bridge, M1 = DMA/aux). One access is in flight
// at a time: grant, one bus strobe cycle, optional read-latency wait, ack.
module fpro_bus_arbiter #(
    parameter int VIDEO_BIT = 20,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [20:0] m0_addr,
    input  logic [31:0] m0_wr_data,
    output logic        m0_ack,
    output logic [31:0] m0_rd_data,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [20:0] m1_addr,
    input  logic [31:0] m1_wr_data,
    output logic        m1_ack,
    output logic [31:0] m1_rd_data,
    output logic        fp_video_cs,
    output logic        fp_mmio_cs,
    output logic        fp_wr,
    output logic        fp_rd,
    output logic [20:0] fp_addr,
    output logic [31:0] fp_wr_data,
    input  logic [31:0] fp_rd_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Read wait counter start value; RD_LAT is limited to 1..4 so two bits suffice.
    localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

    state_t      state_r;
    logic        last_grant_r;  // master granted most recently (1 = M1)
    logic        gnt_r;         // master owning the current transaction
    logic        wr_lat_r;      // latched direction of the current transaction
    logic [1:0]  cnt_r;

    logic        any_req_s;
    logic        pick_s;
    logic        sel_wr_s;
    logic [20:0] sel_addr_s;
    logic [31:0] sel_wr_data_s;

    // Pick the winner: alternate on contention, otherwise serve the lone requester.
    always_comb begin
        any_req_s = m0_req | m1_req;
        if (m0_req && m1_req) begin
            pick_s = ~last_grant_r;
        end else if (m1_req) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Route the winning master's request fields toward the latch stage.
    always_comb begin
        if (pick_s) begin
            sel_wr_s      = m1_wr;
            sel_addr_s    = m1_addr;
            sel_wr_data_s = m1_wr_data;
        end else begin
            sel_wr_s      = m0_wr;
            sel_addr_s    = m0_addr;
            sel_wr_data_s = m0_wr_data;
        end
    end

    // Transaction sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            gnt_r        <= 1'b0;
            wr_lat_r     <= 1'b0;
            cnt_r        <= 2'd0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rd_data   <= 32'h0000_0000;
            m1_rd_data   <= 32'h0000_0000;
            fp_video_cs  <= 1'b0;
            fp_mmio_cs   <= 1'b0;
            fp_wr        <= 1'b0;
            fp_rd        <= 1'b0;
            fp_addr      <= 21'h00_0000;
            fp_wr_data   <= 32'h0000_0000;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        // Latch the winner's fields and drive the bus for the next cycle.
                        gnt_r        <= pick_s;
                        last_grant_r <= pick_s;
                        wr_lat_r     <= sel_wr_s;
                        fp_addr      <= sel_addr_s;
                        fp_wr_data   <= sel_wr_data_s;
                        fp_wr        <= sel_wr_s;
                        fp_rd        <= ~sel_wr_s;
                        fp_video_cs  <= sel_addr_s[VIDEO_BIT];
                        fp_mmio_cs   <= ~sel_addr_s[VIDEO_BIT];
                        busy         <= 1'b1;
                        state_r      <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    // Strobes last exactly one cycle; address and data hold afterwards.
                    fp_wr       <= 1'b0;
                    fp_rd       <= 1'b0;
                    fp_video_cs <= 1'b0;
                    fp_mmio_cs  <= 1'b0;
                    if (wr_lat_r) begin
                        m0_ack  <= ~gnt_r;
                        m1_ack  <= gnt_r;
                        state_r <= ACK;
                    end else begin
                        cnt_r   <= CNT_LOAD;
                        state_r <= RWAIT;
                    end
                end
                RWAIT: begin
                    if (cnt_r == 2'd0) begin
                        if (gnt_r) begin
                            m1_rd_data <= fp_rd_data;
                        end else begin
                            m0_rd_data <= fp_rd_data;
                        end
                        m0_ack  <= ~gnt_r;
                        m1_ack  <= gnt_r;
                        state_r <= ACK;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                ACK: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    m0_ack      <= 1'b0;
                    m1_ack      <= 1'b0;
                    fp_wr       <= 1'b0;
                    fp_rd       <= 1'b0;
                    fp_video_cs <= 1'b0;
                    fp_mmio_cs  <= 1'b0;
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Testbench for fpro_bus_arbiter: directed transactions, expected bus cycles and
// acks queued by the stimulus, compared by independent negedge monitors.
module tb_fpro_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [20:0] m0_addr, m1_addr;
    logic [31:0] m0_wr_data, m1_wr_data;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rd_data, m1_rd_data;
    logic        fp_video_cs, fp_mmio_cs, fp_wr, fp_rd, busy;
    logic [20:0] fp_addr;
    logic [31:0] fp_wr_data, fp_rd_data;

    // second instance with RD_LAT=3 (only M0 used)
    logic        d3_m0_req, d3_m0_wr, d3_m1_req, d3_m1_wr;
    logic [20:0] d3_m0_addr, d3_m1_addr;
    logic [31:0] d3_m0_wr_data, d3_m1_wr_data;
    logic        d3_m0_ack, d3_m1_ack;
    logic [31:0] d3_m0_rd_data, d3_m1_rd_data;
    logic        d3_fp_video_cs, d3_fp_mmio_cs, d3_fp_wr, d3_fp_rd, d3_busy;
    logic [20:0] d3_fp_addr;
    logic [31:0] d3_fp_wr_data, d3_fp_rd_data;

    fpro_bus_arbiter #(.VIDEO_BIT(20), .RD_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
        .fp_video_cs(fp_video_cs), .fp_mmio_cs(fp_mmio_cs), .fp_wr(fp_wr), .fp_rd(fp_rd),
        .fp_addr(fp_addr), .fp_wr_data(fp_wr_data), .fp_rd_data(fp_rd_data), .busy(busy)
    );

    fpro_bus_arbiter #(.VIDEO_BIT(20), .RD_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .m0_req(d3_m0_req), .m0_wr(d3_m0_wr), .m0_addr(d3_m0_addr), .m0_wr_data(d3_m0_wr_data),
        .m0_ack(d3_m0_ack), .m0_rd_data(d3_m0_rd_data),
        .m1_req(d3_m1_req), .m1_wr(d3_m1_wr), .m1_addr(d3_m1_addr), .m1_wr_data(d3_m1_wr_data),
        .m1_ack(d3_m1_ack), .m1_rd_data(d3_m1_rd_data),
        .fp_video_cs(d3_fp_video_cs), .fp_mmio_cs(d3_fp_mmio_cs), .fp_wr(d3_fp_wr), .fp_rd(d3_fp_rd),
        .fp_addr(d3_fp_addr), .fp_wr_data(d3_fp_wr_data), .fp_rd_data(d3_fp_rd_data), .busy(d3_busy)
    );

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int ack_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave models: data valid only in cycle 1+RD_LAT after the read strobe.
    logic [31:0] slave_data = 32'h0;
    logic        s1 = 1'b0;
    logic [2:0]  s3 = 3'b000;
    always @(posedge clk) begin
        s1 <= fp_rd;
        s3 <= {s3[1:0], d3_fp_rd};
    end
    assign fp_rd_data    = s1    ? slave_data : 32'hBAD0_BAD0;
    assign d3_fp_rd_data = s3[2] ? slave_data : 32'hBAD0_BAD0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    typedef struct { int m; logic wr; logic [31:0] rd; int cyc; } ack_t;
    typedef struct { logic wr; logic [20:0] addr; logic [31:0] wd; logic vid; int cyc; } bus_t;
    ack_t ack_q[$];
    ack_t ack3_q[$];
    bus_t bus_q[$];

    // Monitor for the RD_LAT=1 instance.
    always @(negedge clk) begin
        ack_t ea;
        bus_t eb;
        if (m0_ack || m1_ack) begin
            ack_seen++;
            if (ack_q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_ack: m0_ack=%b m1_ack=%b at cycle %0d, none expected", m0_ack, m1_ack, cyc);
            end else begin
                ea = ack_q.pop_front();
                chk("ack_master", {30'd0, m1_ack, m0_ack}, (ea.m == 0) ? 32'd1 : 32'd2);
                chk("ack_cycle", 32'(cyc), 32'(ea.cyc));
                if (!ea.wr) chk("ack_rd_data", (ea.m == 0) ? m0_rd_data : m1_rd_data, ea.rd);
            end
        end
        if (fp_wr || fp_rd) begin
            if (bus_q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_bus: fp_wr=%b fp_rd=%b at cycle %0d, none expected", fp_wr, fp_rd, cyc);
            end else begin
                eb = bus_q.pop_front();
                chk("bus_wr", {31'd0, fp_wr}, {31'd0, eb.wr});
                chk("bus_rd", {31'd0, fp_rd}, {31'd0, !eb.wr});
                chk("bus_addr", {11'd0, fp_addr}, {11'd0, eb.addr});
                chk("bus_video_cs", {31'd0, fp_video_cs}, {31'd0, eb.vid});
                chk("bus_mmio_cs", {31'd0, fp_mmio_cs}, {31'd0, !eb.vid});
                chk("bus_cycle", 32'(cyc), 32'(eb.cyc));
                if (eb.wr) chk("bus_wr_data", fp_wr_data, eb.wd);
            end
        end
    end

    // Monitor for the RD_LAT=3 instance.
    always @(negedge clk) begin
        ack_t ea;
        if (d3_m0_ack || d3_m1_ack) begin
            if (ack3_q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_ack3: at cycle %0d, none expected", cyc);
            end else begin
                ea = ack3_q.pop_front();
                chk("ack3_master", {30'd0, d3_m1_ack, d3_m0_ack}, 32'd1);
                chk("ack3_cycle", 32'(cyc), 32'(ea.cyc));
                chk("ack3_rd_data", d3_m0_rd_data, ea.rd);
            end
        end
    end

    // One isolated transaction on the RD_LAT=1 instance; called at posedge+1 with DUT idle.
    task automatic do_txn(input int m, input logic wr, input logic [20:0] a,
                          input logic [31:0] d, input logic [31:0] rdv);
        int  c0;
        int  nb;
        bit  got;
        bus_t eb;
        ack_t ea;
        c0 = cyc;
        slave_data = rdv;
        eb = '{wr, a, d, a[20], c0 + 1};
        bus_q.push_back(eb);
        ea = '{m, wr, rdv, wr ? c0 + 2 : c0 + 3};
        ack_q.push_back(ea);
        if (m == 0) begin
            m0_wr = wr; m0_addr = a; m0_wr_data = d; m0_req = 1'b1;
        end else begin
            m1_wr = wr; m1_addr = a; m1_wr_data = d; m1_req = 1'b1;
        end
        nb = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (busy) nb++;
            if (m0_ack || m1_ack) got = 1'b1;
        end
        if (!got) begin
            n_chk++;
            $display("FAIL txn_timeout: no ack for master %0d within 20 cycles", m);
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("busy_cycles", 32'(nb), wr ? 32'd2 : 32'd3);
        chk("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int  base;
        int  c0;
        int  n;
        bus_t eb;
        ack_t ea;
        reset_n = 1'b0;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 21'h0; m0_wr_data = 32'h0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 21'h0; m1_wr_data = 32'h0;
        d3_m0_req = 1'b0; d3_m0_wr = 1'b0; d3_m0_addr = 21'h0; d3_m0_wr_data = 32'h0;
        d3_m1_req = 1'b0; d3_m1_wr = 1'b0; d3_m1_addr = 21'h0; d3_m1_wr_data = 32'h0;

        // Test 1: reset state, then reset in the middle of ISSUE
        repeat (3) @(posedge clk);
        #2;
        chk("rst_outputs", {25'd0, fp_wr, fp_rd, fp_video_cs, fp_mmio_cs, m0_ack, m1_ack, busy}, 32'd0);
        chk("rst_rd_data", m0_rd_data | m1_rd_data, 32'd0);
        chk("rst_addr", {11'd0, fp_addr}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        m0_wr = 1'b1; m0_addr = 21'h000030; m0_wr_data = 32'h1111_2222; m0_req = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_issue", {30'd0, fp_wr, busy}, 32'd3);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_strobes", {25'd0, fp_wr, fp_rd, fp_video_cs, fp_mmio_cs, m0_ack, m1_ack, busy}, 32'd0);
        m0_req = 1'b0;
        base = ack_seen;
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_ack_after_rst", 32'(ack_seen), 32'(base));

        // Test 2: M0 write to MMIO space
        do_txn(0, 1'b1, 21'h000010, 32'hDEAD_BEEF, 32'h0);

        // Test 3: M1 read from video space
        do_txn(1, 1'b0, 21'h100004, 32'h0, 32'h1234_5678);
        chk("m1_rd_hold", m1_rd_data, 32'h1234_5678);
        chk("m0_rd_untouched", m0_rd_data, 32'h0);

        // Test 4: continuous contention, six write transactions
        c0 = cyc;
        base = ack_seen;
        m0_wr = 1'b1; m0_addr = 21'h000020; m0_wr_data = 32'hA0A0_0001;
        m1_wr = 1'b1; m1_addr = 21'h100040; m1_wr_data = 32'hB1B1_0002;
        for (int k = 0; k < 6; k++) begin
            if ((k % 2) == 0) eb = '{1'b1, 21'h000020, 32'hA0A0_0001, 1'b0, c0 + 1 + 3 * k};
            else              eb = '{1'b1, 21'h100040, 32'hB1B1_0002, 1'b1, c0 + 1 + 3 * k};
            bus_q.push_back(eb);
            ea = '{k % 2, 1'b1, 32'h0, c0 + 2 + 3 * k};
            ack_q.push_back(ea);
        end
        m0_req = 1'b1;
        m1_req = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 6; i++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) n++;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        if (n < 6) begin
            n_chk++;
            $display("FAIL contention_timeout: saw %0d acks, wanted 6", n);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("contention_acks", 32'(ack_seen - base), 32'd6);

        // Test 6: M1 raises a write while M0 read waits; no preemption
        c0 = cyc;
        slave_data = 32'hCAFE_F00D;
        eb = '{1'b0, 21'h000008, 32'h0, 1'b0, c0 + 1};
        bus_q.push_back(eb);
        ea = '{0, 1'b0, 32'hCAFE_F00D, c0 + 3};
        ack_q.push_back(ea);
        m0_wr = 1'b0; m0_addr = 21'h000008; m0_wr_data = 32'h0; m0_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        eb = '{1'b1, 21'h100100, 32'h55AA_55AA, 1'b1, c0 + 5};
        bus_q.push_back(eb);
        ea = '{1, 1'b1, 32'h0, c0 + 6};
        ack_q.push_back(ea);
        m1_wr = 1'b1; m1_addr = 21'h100100; m1_wr_data = 32'h55AA_55AA; m1_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m0_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("m0_rd_after_m1_wr", m0_rd_data, 32'hCAFE_F00D);
        chk("m1_rd_after_own_wr", m1_rd_data, 32'h1234_5678);

        // Test 5: RD_LAT=3 instance, slave data late
        c0 = cyc;
        slave_data = 32'h8765_4321;
        ea = '{0, 1'b0, 32'h8765_4321, c0 + 5};
        ack3_q.push_back(ea);
        d3_m0_wr = 1'b0; d3_m0_addr = 21'h000044; d3_m0_req = 1'b1;
        @(posedge clk); #1;
        chk("d3_issue", {28'd0, d3_fp_rd, d3_fp_wr, d3_fp_video_cs, d3_fp_mmio_cs}, 32'h9);
        chk("d3_addr", {11'd0, d3_fp_addr}, 32'h44);
        n = 0;
        for (int i = 0; i < 20 && n == 0; i++) begin
            @(posedge clk); #1;
            if (d3_m0_ack) n = 1;
        end
        if (n == 0) begin
            n_chk++;
            $display("FAIL d3_timeout: no ack from RD_LAT=3 instance");
        end
        @(posedge clk); #1;
        d3_m0_req = 1'b0;
        chk("d3_busy_after", {31'd0, d3_busy}, 32'd0);
        chk("d3_m1_rd_data", d3_m1_rd_data, 32'h0);
        chk("d3_wr_data", d3_fp_wr_data, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("ack3_q_drained", 32'(ack3_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
